// File: rtl/bcd_digit_entry_pkg.sv
// Shared definitions for the BCD digit entry block.
//   BCD_MAX / BCD_MIN       : legal digit range
//   ACT_*                   : action encoding from the press priority encoder
//   rpt_state_t             : auto-repeat FSM states (used only with AUTO_REPEAT_EN)
//   bcd_apply()             : digit update for one action, wrapping within 0..9
package bcd_digit_entry_pkg;

    localparam logic [3:0] BCD_MAX = 4'd9;
    localparam logic [3:0] BCD_MIN = 4'd0;

    localparam logic [1:0] ACT_NONE = 2'd0;
    localparam logic [1:0] ACT_INC  = 2'd1;
    localparam logic [1:0] ACT_DEC  = 2'd2;
    localparam logic [1:0] ACT_CLR  = 2'd3;

    typedef enum logic [1:0] {
        RPT_IDLE   = 2'd0,
        RPT_HOLD   = 2'd1,
        RPT_REPEAT = 2'd2
    } rpt_state_t;

    // Illegal codes 10..15 recover to 0 on either step direction.
    function automatic logic [3:0] bcd_apply(input logic [1:0] act, input logic [3:0] cur);
        logic [3:0] res;
        res = cur;
        case (act)
            ACT_CLR: res = BCD_MIN;
            ACT_INC: res = (cur >= BCD_MAX) ? BCD_MIN : cur + 4'd1;
            ACT_DEC: res = (cur == BCD_MIN) ? BCD_MAX :
                           (cur >  BCD_MAX) ? BCD_MIN : cur - 4'd1;
            default: res = cur;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/bcd_digit_entry_debounce.sv
// btn_debounce: one raw button -> synchronised, debounced level plus press pulse.
//   clk, rst_n  : clock, async active-low reset
//   btn_raw     : raw asynchronous button input
//   btn_level   : debounced level
//   btn_press   : one-cycle pulse on the debounced 0->1 edge
module btn_debounce
    import bcd_digit_entry_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 12000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic btn_level,
    output logic btn_press
);

    localparam int             CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          r_sync1, r_sync2;
    logic          r_level, r_level_d;
    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_level   <= 1'b0;
            r_level_d <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_sync1   <= btn_raw;
            r_sync2   <= r_sync1;
            r_level_d <= r_level;
            // The counter holds the run length of disagreeing cycles; it is
            // cleared on the flip, so it can never pass CNT_LAST or wrap.
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt >= CNT_LAST) begin
                r_level <= r_sync2;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign btn_level = r_level;
    assign btn_press = r_level & ~r_level_d;

endmodule

// File: rtl/bcd_digit_entry.sv
// bcd_digit_entry: buttons -> held BCD digit for the BCD->Excess-3 converter.
//   clk, rst_n              : clock, async active-low reset
//   btn_inc/btn_dec/btn_clr : raw active-high buttons
//   bcd_out                 : registered digit, always 0..9
//   digit_strobe            : pulse in the cycle bcd_out takes an applied result
// Optional: define AUTO_REPEAT_EN for hold-to-repeat on inc/dec.
module bcd_digit_entry
    import bcd_digit_entry_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 12000,
    parameter int REPEAT_DELAY    = 6000000,
    parameter int REPEAT_PERIOD   = 2400000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_inc,
    input  logic       btn_dec,
    input  logic       btn_clr,
    output logic [3:0] bcd_out,
    output logic       digit_strobe
);

    logic       w_lvl_inc, w_lvl_dec, w_lvl_clr;
    logic       w_prs_inc, w_prs_dec, w_prs_clr;
    logic [1:0] w_act;
    logic [3:0] r_bcd;
    logic       r_strobe;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_inc (
        .clk(clk), .rst_n(rst_n), .btn_raw(btn_inc), .btn_level(w_lvl_inc), .btn_press(w_prs_inc));
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_dec (
        .clk(clk), .rst_n(rst_n), .btn_raw(btn_dec), .btn_level(w_lvl_dec), .btn_press(w_prs_dec));
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clr (
        .clk(clk), .rst_n(rst_n), .btn_raw(btn_clr), .btn_level(w_lvl_clr), .btn_press(w_prs_clr));

`ifdef AUTO_REPEAT_EN
    localparam int            RPT_MAX  = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int            RW       = $clog2(RPT_MAX + 1);
    localparam logic [RW-1:0] DLY_LAST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] PER_LAST = RW'(REPEAT_PERIOD - 1);

    rpt_state_t    r_rpt_st, w_rpt_nxt;
    logic [RW-1:0] r_rpt_cnt, w_rpt_cnt_nxt;
    logic          r_rpt_inc, w_rpt_inc_nxt;
    logic          w_rpt_step, w_held, w_cancel, w_inc_only, w_dec_only;
    logic          w_unused;

    assign w_unused   = w_lvl_clr;
    assign w_inc_only = w_prs_inc & ~w_prs_dec & ~w_prs_clr;
    assign w_dec_only = w_prs_dec & ~w_prs_inc & ~w_prs_clr;
    assign w_held     = r_rpt_inc ? w_lvl_inc : w_lvl_dec;
    // Release, clr, or the opposite direction ends the repeat sequence.
    assign w_cancel   = ~w_held | w_prs_clr | (r_rpt_inc ? w_prs_dec : w_prs_inc);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rpt_st  <= RPT_IDLE;
            r_rpt_cnt <= '0;
            r_rpt_inc <= 1'b0;
        end else begin
            r_rpt_st  <= w_rpt_nxt;
            r_rpt_cnt <= w_rpt_cnt_nxt;
            r_rpt_inc <= w_rpt_inc_nxt;
        end
    end

    // Driven from the press pulses, not w_act, so there is no loop through the step.
    always_comb begin
        w_rpt_nxt     = r_rpt_st;
        w_rpt_cnt_nxt = r_rpt_cnt + RW'(1);
        w_rpt_inc_nxt = r_rpt_inc;
        w_rpt_step    = 1'b0;
        case (r_rpt_st)
            RPT_IDLE: begin
                w_rpt_cnt_nxt = '0;
                if (w_inc_only || w_dec_only) begin
                    w_rpt_nxt     = RPT_HOLD;
                    w_rpt_inc_nxt = w_inc_only;
                end
            end
            RPT_HOLD, RPT_REPEAT: begin
                if (w_cancel) begin
                    w_rpt_nxt     = RPT_IDLE;
                    w_rpt_cnt_nxt = '0;
                end else if (r_rpt_cnt == ((r_rpt_st == RPT_HOLD) ? DLY_LAST : PER_LAST)) begin
                    w_rpt_step    = 1'b1;
                    w_rpt_nxt     = RPT_REPEAT;
                    w_rpt_cnt_nxt = '0;
                end
            end
            default: begin
                w_rpt_nxt     = RPT_IDLE;
                w_rpt_cnt_nxt = '0;
            end
        endcase
    end
`else
    logic w_unused;
    assign w_unused = ^{w_lvl_inc, w_lvl_dec, w_lvl_clr, REPEAT_DELAY != 0, REPEAT_PERIOD != 0};
`endif

    // Press priority: clr, then inc+dec cancel, then single direction, then repeat step.
    always_comb begin
        w_act = ACT_NONE;
        if (w_prs_clr)                   w_act = ACT_CLR;
        else if (w_prs_inc && w_prs_dec) w_act = ACT_NONE;
        else if (w_prs_inc)              w_act = ACT_INC;
        else if (w_prs_dec)              w_act = ACT_DEC;
`ifdef AUTO_REPEAT_EN
        else if (w_rpt_step)             w_act = r_rpt_inc ? ACT_INC : ACT_DEC;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bcd    <= BCD_MIN;
            r_strobe <= 1'b0;
        end else begin
            r_strobe <= (w_act != ACT_NONE);
            if (w_act != ACT_NONE) r_bcd <= bcd_apply(w_act, r_bcd);
        end
    end

    assign bcd_out      = r_bcd;
    assign digit_strobe = r_strobe;

endmodule

// File: tb/tb_bcd_digit_entry.sv
module tb_bcd_digit_entry;

    localparam int DEB = 4;
    localparam int RD  = 20;
    localparam int RP  = 8;

    logic       clk, rst_n, btn_inc, btn_dec, btn_clr;
    logic [3:0] bcd_out;
    logic       digit_strobe;
    int         n_tot, n_bad;

    bcd_digit_entry #(.DEBOUNCE_CYCLES(DEB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut (
        .clk(clk), .rst_n(rst_n), .btn_inc(btn_inc), .btn_dec(btn_dec), .btn_clr(btn_clr),
        .bcd_out(bcd_out), .digit_strobe(digit_strobe));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Raw sample at edge n is seen by the debouncer at edge n+2; a level flips
    // when the last DEB seen samples (all taken after reset) oppose it.
    logic [2:0]          m_raw;
    logic [2:0][1:0]     m_rh;
    logic [2:0][DEB-2:0] m_sh;
    int                  m_fill, m_cyc, m_ht, m_k;
    logic [2:0]          m_lvl, m_prs, m_flip;
    logic [3:0]          m_bcd;
    logic                m_stb, m_hold, m_hinc, m_cancel, m_step;

    assign m_raw = {btn_clr, btn_dec, btn_inc};

    always_comb begin
        m_flip = '0;
        for (int b = 0; b < 3; b++)
            m_flip[b] = (m_fill >= DEB - 1) && ({m_sh[b], m_rh[b][1]} == {DEB{~m_lvl[b]}});
        m_k      = m_cyc - m_ht;
        m_cancel = !(m_hinc ? m_lvl[0] : m_lvl[1]) || m_prs[2] || (m_hinc ? m_prs[1] : m_prs[0]);
        m_step   = 1'b0;
`ifdef AUTO_REPEAT_EN
        m_step   = m_hold && !m_cancel && (m_k >= RD) && (((m_k - RD) % RP) == 0);
`endif
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_rh <= '0; m_sh <= '0; m_fill <= 0; m_cyc <= 0; m_ht <= 0;
            m_lvl <= '0; m_prs <= '0; m_bcd <= 4'd0; m_stb <= 1'b0;
            m_hold <= 1'b0; m_hinc <= 1'b0;
        end else begin
            m_cyc <= m_cyc + 1;
            if (m_fill < DEB - 1) m_fill <= m_fill + 1;
            for (int b = 0; b < 3; b++) begin
                m_rh[b] <= {m_rh[b][0], m_raw[b]};
                m_sh[b] <= {m_sh[b][DEB-3:0], m_rh[b][1]};
            end
            m_lvl <= m_lvl ^ m_flip;
            m_prs <= m_flip & ~m_lvl;
            m_stb <= 1'b0;
            if (m_prs[2]) begin
                m_bcd <= 4'd0; m_stb <= 1'b1;
            end else if (m_prs[0] && m_prs[1]) begin
                m_stb <= 1'b0;
            end else if (m_prs[0] || (m_step && m_hinc)) begin
                m_bcd <= 4'((m_bcd + 1) % 10); m_stb <= 1'b1;
            end else if (m_prs[1] || m_step) begin
                m_bcd <= 4'((m_bcd + 9) % 10); m_stb <= 1'b1;
            end
            if (m_hold) begin
                if (m_cancel) m_hold <= 1'b0;
            end else if ((m_prs[0] ^ m_prs[1]) && !m_prs[2]) begin
                m_hold <= 1'b1; m_hinc <= m_prs[0]; m_ht <= m_cyc;
            end
        end
    end

    // ---------------- stimulus helper (no checking) ----------------
    task automatic pulse_btn(input logic [2:0] b);
        {btn_clr, btn_dec, btn_inc} = b;
        repeat (8) @(negedge clk);
        {btn_clr, btn_dec, btn_inc} = 3'b000;
        repeat (10) @(negedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0; btn_inc = 1'b0; btn_dec = 1'b0; btn_clr = 1'b0;
        repeat (3) @(negedge clk);
        n_tot++;
        if (bcd_out !== 4'd0 || digit_strobe !== 1'b0) begin
            n_bad++; $display("FAIL reset_state got %0d/%0b want 0/0", bcd_out, digit_strobe);
        end
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            n_tot++;
            if (bcd_out !== 4'd0 || digit_strobe !== 1'b0) begin
                n_bad++; $display("FAIL reset_idle cyc=%0d got %0d/%0b want 0/0", c, bcd_out, digit_strobe);
            end
        end
    endtask

    task automatic test_inc();
        for (int i = 1; i <= 10; i++) begin
            btn_inc = 1'b1;
            for (int c = 1; c <= 16; c++) begin
                @(negedge clk);
                if (c == 8) btn_inc = 1'b0;
                n_tot++;
                if (bcd_out !== m_bcd || digit_strobe !== m_stb) begin
                    n_bad++; $display("FAIL inc_model p=%0d c=%0d got %0d/%0b want %0d/%0b", i, c, bcd_out, digit_strobe, m_bcd, m_stb);
                end
                if (c == 6) begin
                    n_tot++;
                    if (digit_strobe !== 1'b0) begin
                        n_bad++; $display("FAIL inc_early p=%0d got stb=%0b want 0", i, digit_strobe);
                    end
                end
                if (c == 7) begin
                    n_tot++;
                    if (digit_strobe !== 1'b1 || bcd_out !== 4'(i % 10)) begin
                        n_bad++; $display("FAIL inc_step p=%0d got %0d/%0b want %0d/1", i, bcd_out, digit_strobe, i % 10);
                    end
                end
            end
        end
    endtask

    task automatic test_dec();
        for (int i = 0; i < 2; i++) begin
            btn_dec = 1'b1;
            for (int c = 1; c <= 16; c++) begin
                @(negedge clk);
                if (c == 8) btn_dec = 1'b0;
                n_tot++;
                if (bcd_out !== m_bcd || digit_strobe !== m_stb) begin
                    n_bad++; $display("FAIL dec_model p=%0d c=%0d got %0d/%0b want %0d/%0b", i, c, bcd_out, digit_strobe, m_bcd, m_stb);
                end
                if (c == 7) begin
                    n_tot++;
                    if (digit_strobe !== 1'b1 || bcd_out !== ((i == 0) ? 4'd9 : 4'd8)) begin
                        n_bad++; $display("FAIL dec_step p=%0d got %0d/%0b want %0d/1", i, bcd_out, digit_strobe, (i == 0) ? 9 : 8);
                    end
                end
            end
        end
    endtask

    task automatic test_bounce();
        int n_stb_bounce, n_stb_all;
        n_stb_bounce = 0; n_stb_all = 0;
        for (int c = 0; c < 60; c++) begin
            btn_inc = (c < 30) ? ~c[1] : (c < 42);
            @(negedge clk);
            if (digit_strobe === 1'b1) begin
                n_stb_all++;
                if (c < 30) n_stb_bounce++;
            end
            n_tot++;
            if (bcd_out !== m_bcd || digit_strobe !== m_stb) begin
                n_bad++; $display("FAIL bounce_model c=%0d got %0d/%0b want %0d/%0b", c, bcd_out, digit_strobe, m_bcd, m_stb);
            end
        end
        n_tot++;
        if (n_stb_bounce !== 0 || n_stb_all !== 1 || bcd_out !== 4'd9) begin
            n_bad++; $display("FAIL bounce_count got bounce=%0d all=%0d bcd=%0d want 0 1 9", n_stb_bounce, n_stb_all, bcd_out);
        end
    endtask

    task automatic test_simul();
        int n_stb;
        pulse_btn(3'b100);
        for (int i = 0; i < 5; i++) pulse_btn(3'b001);
        n_tot++;
        if (bcd_out !== 4'd5) begin
            n_bad++; $display("FAIL simul_setup got %0d want 5", bcd_out);
        end
        n_stb = 0;
        {btn_dec, btn_inc} = 2'b11;
        for (int c = 1; c <= 18; c++) begin
            @(negedge clk);
            if (c == 8) {btn_dec, btn_inc} = 2'b00;
            if (digit_strobe === 1'b1) n_stb++;
        end
        n_tot++;
        if (n_stb !== 0 || bcd_out !== 4'd5) begin
            n_bad++; $display("FAIL simul_incdec got strobes=%0d bcd=%0d want 0 5", n_stb, bcd_out);
        end
        {btn_clr, btn_dec, btn_inc} = 3'b111;
        for (int c = 1; c <= 18; c++) begin
            @(negedge clk);
            if (c == 8) {btn_clr, btn_dec, btn_inc} = 3'b000;
            if (c == 7) begin
                n_tot++;
                if (bcd_out !== 4'd0 || digit_strobe !== 1'b1) begin
                    n_bad++; $display("FAIL simul_all got %0d/%0b want 0/1", bcd_out, digit_strobe);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        pulse_btn(3'b001);
        pulse_btn(3'b001);
        btn_inc = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_tot++;
        if (bcd_out !== 4'd0 || digit_strobe !== 1'b0) begin
            n_bad++; $display("FAIL rst_mid got %0d/%0b want 0/0", bcd_out, digit_strobe);
        end
        @(negedge clk);
        btn_inc = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            n_tot++;
            if (bcd_out !== 4'd0 || digit_strobe !== 1'b0 || m_stb !== 1'b0) begin
                n_bad++; $display("FAIL rst_after c=%0d got %0d/%0b want 0/0", c, bcd_out, digit_strobe);
            end
        end
    endtask

    task automatic test_random();
        for (int s = 0; s < 150; s++) begin
            int len;
            logic [2:0] b;
            b   = 3'($urandom_range(0, 7));
            len = $urandom_range(1, 30);
            {btn_clr, btn_dec, btn_inc} = b;
            for (int c = 0; c < len; c++) begin
                @(negedge clk);
                n_tot++;
                if (bcd_out !== m_bcd || digit_strobe !== m_stb) begin
                    n_bad++; $display("FAIL rand_model seg=%0d c=%0d btn=%b got %0d/%0b want %0d/%0b", s, c, b, bcd_out, digit_strobe, m_bcd, m_stb);
                end
            end
        end
        {btn_clr, btn_dec, btn_inc} = 3'b000;
        repeat (12) @(negedge clk);
    endtask

`ifdef AUTO_REPEAT_EN
    task automatic test_repeat();
        logic [3:0] want;
        pulse_btn(3'b100);
        btn_inc = 1'b1;
        for (int c = 1; c <= 85; c++) begin
            @(negedge clk);
            if (c == 60) btn_inc = 1'b0;
            n_tot++;
            if (bcd_out !== m_bcd || digit_strobe !== m_stb) begin
                n_bad++; $display("FAIL rpt_model c=%0d got %0d/%0b want %0d/%0b", c, bcd_out, digit_strobe, m_bcd, m_stb);
            end
            want = 4'd0;
            if (c >= 7)  want = 4'd1;
            if (c >= 27) want = 4'(2 + (c - 27) / 8);
            if (want > 4'd6) want = 4'd6;
            if (c == 7 || c == 27 || c == 35 || c == 43 || c == 59 || c == 85) begin
                n_tot++;
                if (bcd_out !== want) begin
                    n_bad++; $display("FAIL rpt_step c=%0d got %0d want %0d", c, bcd_out, want);
                end
            end
        end
    endtask
`endif

    initial begin
        n_tot = 0; n_bad = 0;
        test_reset();
        test_inc();
        test_dec();
        test_bounce();
        test_simul();
        test_reset_mid();
        test_random();
`ifdef AUTO_REPEAT_EN
        test_repeat();
`endif
        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
